// File: rtl/uart_relay_fifo.sv
// UART man-in-the-middle relay core: host command parser with ack, plus one FIFO
// per direction (A->B, B->A) with saturating drop counters and OFF/FORCE/NORMAL/SUBST modes.
module uart_relay_fifo #(
    parameter int              DW         = 8,
    parameter int              FIFO_AW    = 4,
    parameter logic [DW-1:0]   FORCE_BYTE = 8'h47,
    parameter int              CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic [DW-1:0]     host_rx_data,
    input  logic              host_rx_valid,
    output logic [DW-1:0]     host_tx_data,
    output logic              host_tx_en,
    input  logic              host_tx_ready,
    input  logic [DW-1:0]     a_rx_data,
    input  logic              a_rx_valid,
    output logic [DW-1:0]     a_tx_data,
    output logic              a_tx_en,
    input  logic              a_tx_ready,
    input  logic [DW-1:0]     b_rx_data,
    input  logic              b_rx_valid,
    output logic [DW-1:0]     b_tx_data,
    output logic              b_tx_en,
    input  logic              b_tx_ready,
    output logic [1:0]        mode,
    output logic              led,
    output logic [CNT_W-1:0]  drop_ab,
    output logic [CNT_W-1:0]  drop_ba
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_FORCE  = 2'd1,
        MODE_NORMAL = 2'd2,
        MODE_SUBST  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_GET_M = 2'd1,
        P_GET_R = 2'd2
    } parse_t;

    localparam logic [DW-1:0] CH_O = DW'(8'h4F);
    localparam logic [DW-1:0] CH_G = DW'(8'h47);
    localparam logic [DW-1:0] CH_N = DW'(8'h4E);
    localparam logic [DW-1:0] CH_S = DW'(8'h53);

    parse_t         state_reg, state_next;
    mode_t          mode_reg, mode_next;
    logic [DW-1:0]  match_reg, match_next;
    logic [DW-1:0]  repl_reg, repl_next;
    logic           cmd_done;
    logic [DW-1:0]  ack_new;
    logic           led_reg;
    logic           ack_pend_reg;
    logic [DW-1:0]  ack_byte_reg;
    logic           host_tx_en_reg;
    logic [DW-1:0]  host_tx_data_reg;

    // ------------------------------------------------------------------
    // Command parser
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        match_next = match_reg;
        repl_next  = repl_reg;
        cmd_done   = 1'b0;
        ack_new    = '0;
        if (host_rx_valid) begin
            case (state_reg)
                P_IDLE: begin
                    if (host_rx_data == CH_O) begin
                        mode_next = MODE_OFF;
                        cmd_done  = 1'b1;
                        ack_new   = CH_O;
                    end else if (host_rx_data == CH_G) begin
                        mode_next = MODE_FORCE;
                        cmd_done  = 1'b1;
                        ack_new   = CH_G;
                    end else if (host_rx_data == CH_N) begin
                        mode_next = MODE_NORMAL;
                        cmd_done  = 1'b1;
                        ack_new   = CH_N;
                    end else if (host_rx_data == CH_S) begin
                        state_next = P_GET_M;
                    end
                end
                P_GET_M: begin
                    match_next = host_rx_data;
                    state_next = P_GET_R;
                end
                P_GET_R: begin
                    repl_next  = host_rx_data;
                    mode_next  = MODE_SUBST;
                    cmd_done   = 1'b1;
                    ack_new    = CH_S;
                    state_next = P_IDLE;
                end
                default: state_next = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= P_IDLE;
            mode_reg  <= MODE_OFF;
            match_reg <= '0;
            repl_reg  <= '0;
            led_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            match_reg <= match_next;
            repl_reg  <= repl_next;
            if (cmd_done)
                led_reg <= ~led_reg;
        end
    end

    // ------------------------------------------------------------------
    // Ack register: a newer command overwrites an ack that has not gone out yet
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ack_pend_reg     <= 1'b0;
            ack_byte_reg     <= '0;
            host_tx_en_reg   <= 1'b0;
            host_tx_data_reg <= '0;
        end else begin
            host_tx_en_reg <= 1'b0;
            if (ack_pend_reg && host_tx_ready && !host_tx_en_reg) begin
                host_tx_en_reg   <= 1'b1;
                host_tx_data_reg <= ack_byte_reg;
                ack_pend_reg     <= 1'b0;
            end
            if (cmd_done) begin
                ack_pend_reg <= 1'b1;
                ack_byte_reg <= ack_new;
            end
        end
    end

    // Pushes follow the mode at cycle start; en decisions follow the mode being
    // entered so that no pulse appears after switching to an illegal mode.
    logic push_ok;
    logic relay_ok;
    logic force_ok;
    logic flush;

    assign push_ok  = (mode_reg == MODE_NORMAL) || (mode_reg == MODE_SUBST);
    assign relay_ok = (mode_next == MODE_NORMAL) || (mode_next == MODE_SUBST);
    assign force_ok = (mode_next == MODE_FORCE);
    assign flush    = cmd_done && ((mode_next == MODE_OFF) || (mode_next == MODE_FORCE));

    // ------------------------------------------------------------------
    // Direction 0: A rx -> B tx, direction 1: B rx -> A tx
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dir
            logic [DW-1:0]    rx_data;
            logic             rx_valid;
            logic             tx_ready;
            logic [DW-1:0]    mem [2**FIFO_AW];
            logic [FIFO_AW:0] wr_ptr_reg;
            logic [FIFO_AW:0] rd_ptr_reg;
            logic [CNT_W-1:0] drop_reg;
            logic             tx_en_reg;
            logic [DW-1:0]    tx_data_reg;
            logic             full;
            logic             empty;
            logic [DW-1:0]    head;
            logic             push;
            logic             drop_inc;
            logic             pop;
            logic             en_next;
            logic [DW-1:0]    data_next;

            assign rx_data  = (gi == 0) ? a_rx_data  : b_rx_data;
            assign rx_valid = (gi == 0) ? a_rx_valid : b_rx_valid;
            assign tx_ready = (gi == 0) ? b_tx_ready : a_tx_ready;

            assign full  = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                           (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
            assign empty = (wr_ptr_reg == rd_ptr_reg);
            // Asynchronous read keeps rx-to-en latency at two cycles.
            assign head  = mem[rd_ptr_reg[FIFO_AW-1:0]];

            assign push     = rx_valid && push_ok && !full;
            assign drop_inc = rx_valid && push_ok && full && (drop_reg != {CNT_W{1'b1}});
            assign pop      = relay_ok && !empty && tx_ready && !tx_en_reg;

            always_comb begin
                en_next   = 1'b0;
                data_next = tx_data_reg;
                if (force_ok && tx_ready && !tx_en_reg) begin
                    en_next   = 1'b1;
                    data_next = FORCE_BYTE;
                end else if (pop) begin
                    en_next   = 1'b1;
                    data_next = ((mode_next == MODE_SUBST) && (head == match_next)) ? repl_next : head;
                end
            end

            always_ff @(posedge CLK) begin
                if (push)
                    mem[wr_ptr_reg[FIFO_AW-1:0]] <= rx_data;
            end

            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg  <= '0;
                    rd_ptr_reg  <= '0;
                    drop_reg    <= '0;
                    tx_en_reg   <= 1'b0;
                    tx_data_reg <= '0;
                end else begin
                    if (flush) begin
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                    end else begin
                        if (push)
                            wr_ptr_reg <= wr_ptr_reg + (FIFO_AW+1)'(1);
                        if (pop)
                            rd_ptr_reg <= rd_ptr_reg + (FIFO_AW+1)'(1);
                    end
                    if (drop_inc)
                        drop_reg <= drop_reg + CNT_W'(1);
                    tx_en_reg   <= en_next;
                    tx_data_reg <= data_next;
                end
            end
        end
    endgenerate

    assign b_tx_en      = g_dir[0].tx_en_reg;
    assign b_tx_data    = g_dir[0].tx_data_reg;
    assign drop_ab      = g_dir[0].drop_reg;
    assign a_tx_en      = g_dir[1].tx_en_reg;
    assign a_tx_data    = g_dir[1].tx_data_reg;
    assign drop_ba      = g_dir[1].drop_reg;
    assign host_tx_en   = host_tx_en_reg;
    assign host_tx_data = host_tx_data_reg;
    assign mode         = mode_reg;
    assign led          = led_reg;

endmodule

// File: tb/tb_uart_relay_fifo.sv
// Directed self-checking bench for uart_relay_fifo: commands, relay, drops,
// substitution, force/off, simultaneous pops and mid-command reset.
module tb_uart_relay_fifo;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic [DW-1:0] host_rx_data;
    logic          host_rx_valid;
    logic [DW-1:0] host_tx_data;
    logic          host_tx_en;
    logic          host_tx_ready;
    logic [DW-1:0] a_rx_data;
    logic          a_rx_valid;
    logic [DW-1:0] a_tx_data;
    logic          a_tx_en;
    logic          a_tx_ready;
    logic [DW-1:0] b_rx_data;
    logic          b_rx_valid;
    logic [DW-1:0] b_tx_data;
    logic          b_tx_en;
    logic          b_tx_ready;
    logic [1:0]    mode;
    logic          led;
    logic [CW-1:0] drop_ab;
    logic [CW-1:0] drop_ba;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] a_q[$];
    logic [7:0] b_q[$];
    logic [7:0] h_q[$];

    always #5 CLK = ~CLK;

    uart_relay_fifo #(
        .DW(DW), .FIFO_AW(AW), .FORCE_BYTE(8'h47), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .rst_n(rst_n),
        .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid),
        .host_tx_data(host_tx_data), .host_tx_en(host_tx_en), .host_tx_ready(host_tx_ready),
        .a_rx_data(a_rx_data), .a_rx_valid(a_rx_valid),
        .a_tx_data(a_tx_data), .a_tx_en(a_tx_en), .a_tx_ready(a_tx_ready),
        .b_rx_data(b_rx_data), .b_rx_valid(b_rx_valid),
        .b_tx_data(b_tx_data), .b_tx_en(b_tx_en), .b_tx_ready(b_tx_ready),
        .mode(mode), .led(led), .drop_ab(drop_ab), .drop_ba(drop_ba)
    );

    // Transmit capture on the falling edge, away from the active edge
    always @(negedge CLK) begin
        if (a_tx_en)    a_q.push_back(a_tx_data);
        if (b_tx_en)    b_q.push_back(b_tx_data);
        if (host_tx_en) h_q.push_back(host_tx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %s: observed 0x%0h expected 0x%0h ok", tag, obs, exp);
        end else
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic host_send(input logic [7:0] d);
        @(negedge CLK);
        host_rx_data  = d;
        host_rx_valid = 1'b1;
        @(negedge CLK);
        host_rx_valid = 1'b0;
    endtask

    function automatic logic [31:0] q_at(input logic [7:0] q[$], input int i);
        return (i < q.size()) ? {24'h0, q[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] all_force(input logic [7:0] q[$]);
        logic ok;
        ok = (q.size() >= 4);
        foreach (q[i]) if (q[i] !== 8'h47) ok = 1'b0;
        return {31'h0, ok};
    endfunction

    initial begin
        rst_n = 1'b0;
        host_rx_data = '0; host_rx_valid = 1'b0; host_tx_ready = 1'b1;
        a_rx_data = '0; a_rx_valid = 1'b0; a_tx_ready = 1'b1;
        b_rx_data = '0; b_rx_valid = 1'b0; b_tx_ready = 1'b1;

        // Reset state
        idle(3);
        check("rst_mode", mode, 0);
        check("rst_led", led, 0);
        check("rst_drop_ab", drop_ab, 0);
        check("rst_host_en", host_tx_en, 0);
        check("rst_a_data", a_tx_data, 0);
        rst_n = 1'b1;
        idle(2);

        // T1: 'N' then 0x11,0x22,0x33 relayed A->B
        host_send(8'h4E);
        idle(3);
        check("t1_mode", mode, 2);
        check("t1_led", led, 1);
        check("t1_ack_cnt", h_q.size(), 1);
        check("t1_ack", q_at(h_q, 0), 32'h4E);
        b_q.delete();
        @(negedge CLK); a_rx_data = 8'h11; a_rx_valid = 1'b1;
        @(negedge CLK); a_rx_data = 8'h22;
        @(negedge CLK); a_rx_data = 8'h33;
        @(negedge CLK); a_rx_valid = 1'b0;
        idle(10);
        check("t1_b_cnt", b_q.size(), 3);
        check("t1_b0", q_at(b_q, 0), 32'h11);
        check("t1_b1", q_at(b_q, 1), 32'h22);
        check("t1_b2", q_at(b_q, 2), 32'h33);

        // T2: B blocked, 19 bytes -> 16 kept, 3 dropped
        b_q.delete();
        b_tx_ready = 1'b0;
        for (int i = 0; i < 19; i++) begin
            @(negedge CLK); a_rx_data = 8'h80 + 8'(i); a_rx_valid = 1'b1;
        end
        @(negedge CLK); a_rx_valid = 1'b0;
        idle(2);
        check("t2_drop_ab", drop_ab, 3);
        check("t2_drop_ba", drop_ba, 0);
        check("t2_blocked", b_q.size(), 0);
        b_tx_ready = 1'b1;
        idle(40);
        check("t2_b_cnt", b_q.size(), 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("t2_b%0d", i), q_at(b_q, i), 32'h80 + i);

        // T5: simultaneous A and B strobes -> both en two clocks later
        @(negedge CLK);
        a_rx_data = 8'h5A; a_rx_valid = 1'b1;
        b_rx_data = 8'hA5; b_rx_valid = 1'b1;
        @(negedge CLK);
        a_rx_valid = 1'b0; b_rx_valid = 1'b0;
        check("t5_en_t1", {a_tx_en, b_tx_en}, 2'b00);
        @(negedge CLK);
        check("t5_en_t2", {a_tx_en, b_tx_en}, 2'b11);
        check("t5_b_data", b_tx_data, 32'h5A);
        check("t5_a_data", a_tx_data, 32'hA5);
        idle(4);

        // T3: SUBST 0x41 -> 0x5A in both directions
        h_q.delete();
        host_send(8'h53);
        host_send(8'h41);
        check("t3_mode_getr", mode, 2);
        host_send(8'h5A);
        check("t3_mode", mode, 3);
        check("t3_led", led, 0);
        a_q.delete(); b_q.delete();
        @(negedge CLK); a_rx_data = 8'h41; a_rx_valid = 1'b1; b_rx_data = 8'h41; b_rx_valid = 1'b1;
        @(negedge CLK); a_rx_data = 8'h42; b_rx_valid = 1'b0;
        @(negedge CLK); a_rx_valid = 1'b0;
        idle(8);
        check("t3_ack", q_at(h_q, 0), 32'h53);
        check("t3_b_cnt", b_q.size(), 2);
        check("t3_b0", q_at(b_q, 0), 32'h5A);
        check("t3_b1", q_at(b_q, 1), 32'h42);
        check("t3_a_cnt", a_q.size(), 1);
        check("t3_a0", q_at(a_q, 0), 32'h5A);

        // T4: FORCE emits 'G' on both ports, rx ignored; then OFF stops all en
        h_q.delete();
        host_send(8'h47);
        idle(1);
        a_q.delete(); b_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK); a_rx_data = 8'h99; a_rx_valid = 1'b1; b_rx_data = 8'h98; b_rx_valid = 1'b1;
        end
        @(negedge CLK); a_rx_valid = 1'b0; b_rx_valid = 1'b0;
        idle(4);
        check("t4_mode", mode, 1);
        check("t4_ack", q_at(h_q, 0), 32'h47);
        check("t4_a_force", all_force(a_q), 1);
        check("t4_b_force", all_force(b_q), 1);
        check("t4_drop_ab", drop_ab, 3);
        check("t4_drop_ba", drop_ba, 0);
        h_q.delete();
        host_send(8'h4F);
        idle(2);
        a_q.delete(); b_q.delete();
        idle(10);
        check("t4_off_mode", mode, 0);
        check("t4_off_ack", q_at(h_q, 0), 32'h4F);
        check("t4_off_a", a_q.size(), 0);
        check("t4_off_b", b_q.size(), 0);

        // Unknown byte in IDLE: no ack, no toggle
        h_q.delete();
        host_send(8'h58);
        idle(4);
        check("x_ack_cnt", h_q.size(), 0);
        check("x_led", led, 0);

        // T6: reset with half-full FIFO and parser in GET_R
        host_send(8'h4E);
        b_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK); a_rx_data = 8'hC0 + 8'(i); a_rx_valid = 1'b1;
        end
        @(negedge CLK); a_rx_valid = 1'b0;
        host_send(8'h53);
        host_send(8'h10);
        @(negedge CLK); rst_n = 1'b0;
        @(negedge CLK);
        check("t6_mode", mode, 0);
        check("t6_led", led, 0);
        check("t6_drop_ab", drop_ab, 0);
        check("t6_b_data", b_tx_data, 0);
        check("t6_b_en", b_tx_en, 0);
        rst_n = 1'b1;
        b_tx_ready = 1'b1;
        idle(2);
        h_q.delete(); b_q.delete();
        host_send(8'h4E);
        idle(3);
        check("t6_n_mode", mode, 2);
        check("t6_n_led", led, 1);
        check("t6_n_ack", q_at(h_q, 0), 32'h4E);
        @(negedge CLK); a_rx_data = 8'h11; a_rx_valid = 1'b1;
        @(negedge CLK); a_rx_data = 8'h22;
        @(negedge CLK); a_rx_data = 8'h33;
        @(negedge CLK); a_rx_valid = 1'b0;
        idle(10);
        check("t6_b_cnt", b_q.size(), 3);
        check("t6_b0", q_at(b_q, 0), 32'h11);
        check("t6_b2", q_at(b_q, 2), 32'h33);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
